usb_tx_sched: RTL and testbench
===============================

USB_TX_SCHED -- requirements
Module: usb_tx_sched

Interface
REQ-001 The module SHALL have parameter IPG_CYCLES, default 16, meaning idle clocks enforced between packets (tx_valid low).
REQ-002 The module SHALL have port clk, input, 1, the single clock.
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port hs_req, input, 1, handshake packet request (level, held until hs_done).
REQ-005 The module SHALL have port hs_pid, input, 4, handshake PID (ACK/NAK/STALL), stable while hs_req.
REQ-006 The module SHALL have port hs_done, output, 1, one-clock pulse when the handshake packet completes.
REQ-007 The module SHALL have port dat_req, input, 1, data packet request (level, held until dat_done).
REQ-008 The module SHALL have port dat_pid, input, 4, DATA0/DATA1 PID, stable while dat_req.
REQ-009 The module SHALL have port dat_zlp, input, 1, zero-length packet flag, stable while dat_req.
REQ-010 The module SHALL have ports ep_data (input, 8), ep_valid (input, 1), ep_last (input, 1) and ep_ready (output, 1), forming the payload byte stream.
REQ-011 The module SHALL have port dat_done, output, 1, one-clock pulse when the data packet ends, normally or by underrun.
REQ-012 The module SHALL have port err_underrun, output, 1, one-clock pulse on payload underrun.
REQ-013 The module SHALL have ports data_in (output, 8), tx_valid (output, 1) and tx_ready (input, 1), forming the UTMI transmit side toward usb_utm_tx.
REQ-014 The module SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, PID, DATA, CRC_LO, CRC_HI and IPG.
REQ-016 In IDLE, hs_req SHALL take priority over dat_req when both are high; the winner is latched and the next state is PID.
REQ-017 In PID, tx_valid=1 and data_in={~pid,pid} SHALL be driven; on tx_ready the state SHALL go to IPG (handshake), CRC_LO (dat_zlp) or DATA.
REQ-018 A byte SHALL be consumed only on a clock where tx_valid and tx_ready are both high; data_in SHALL stay stable otherwise.
REQ-019 data_in and tx_valid SHALL be registered; the byte following an accepted byte SHALL be presented on the next clock, and tx_valid SHALL not drop between PID and the last CRC byte.
REQ-020 ep_ready SHALL equal (state==PID or DATA) and tx_ready and (payload byte needed), so that ep_data is loaded into data_in on the accept edge.
REQ-021 DATA SHALL be entered with the first payload byte already loaded; a byte accepted with ep_last set SHALL move the state to CRC_LO.
REQ-022 If ep_valid=0 when a payload byte is needed, the module SHALL set tx_valid=0, pulse err_underrun and dat_done, and go to IPG with no CRC sent.
REQ-023 CRC16 SHALL use poly 0x8005 (reflected), init 0xFFFF, updated on each payload byte taken; CRC_LO SHALL send ~crc[7:0] and CRC_HI SHALL send ~crc[15:8].
REQ-024 On acceptance of the CRC_HI byte, the module SHALL drop tx_valid, pulse dat_done and go to IPG.
REQ-025 The handshake path SHALL pulse hs_done when its PID byte is accepted.
REQ-026 IPG SHALL hold tx_valid=0 for exactly IPG_CYCLES clocks and then return to IDLE; requests arriving in IPG SHALL wait.
REQ-027 The IPG counter SHALL be $clog2(IPG_CYCLES+1) bits wide; IPG_CYCLES=0 SHALL mean a direct return to IDLE.
REQ-028 A request deasserted mid-packet SHALL be ignored; the packet SHALL complete.

Reset
REQ-029 When rst_n=0, the module SHALL asynchronously force state=IDLE, tx_valid=0, data_in=0x00, ep_ready=0, busy=0, all pulses=0, crc=0xFFFF and ipg counter=0, including mid-packet.
REQ-030 After reset release, the first request SHALL be honoured from IDLE with no IPG.

Structure
REQ-031 usb_utmi_pkg SHALL hold the usb_pid_t enum (ACK=0x2, NAK=0xA, STALL=0xE, DATA0=0x3, DATA1=0xB), the CRC16 poly/init/residual constants and bus8_t.
REQ-032 Byte-wise CRC16 update SHALL be a combinational sub-module, usb_crc16, instantiated once.

Verification
REQ-033 hs_req=1, hs_pid=ACK, tx_ready always 1 -> one byte 0xD2, then hs_done pulse, then tx_valid low for 16 clocks.
REQ-034 dat_req, DATA1, dat_zlp=1 -> bytes 0x4B, 0x00, 0x00, then dat_done.
REQ-035 dat_req, DATA0, payload 4 bytes, tx_ready toggling 1-of-3 -> bytes 0xC3, payload unchanged, then CRC matching the model with the residual check 0x800D passing.
REQ-036 hs_req and dat_req rising on the same clock -> handshake is sent first, then the data packet starts after IPG.
REQ-037 ep_valid=0 before the 2nd payload byte -> tx_valid drops, err_underrun and dat_done pulse together, no CRC.
REQ-038 rst_n asserted during DATA -> tx_valid=0 immediately (asynchronous), and a new request after release starts cleanly with a PID byte.

Source files
------------

// File: rtl/usb_utmi_pkg.sv
// Shared USB UTMI transmit types: PID encodings, CRC16 constants and byte helpers.
package usb_utmi_pkg;

  typedef logic [7:0] bus8_t;

  typedef enum logic [3:0] {
    ACK   = 4'h2,
    NAK   = 4'hA,
    STALL = 4'hE,
    DATA0 = 4'h3,
    DATA1 = 4'hB
  } usb_pid_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_IPG
  } tx_state_t;

  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // PID byte carries the check nibble in the upper half
  function automatic bus8_t pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wise USB CRC16 update, LSB-first with the reflected polynomial.
module usb_crc16
  import usb_utmi_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

  logic [15:0] acc;

  always_comb begin
    acc = crc_in;
    for (int i = 0; i < 8; i++) begin
      acc = (acc[0] ^ data[i]) ? ((acc >> 1) ^ POLY_REFL) : (acc >> 1);
    end
    crc_out = acc;
  end

endmodule

// File: rtl/usb_tx_sched.sv
// Transmit scheduler: serialises handshake and data packets (PID, payload, CRC16)
// toward the UTMI transmitter and enforces an inter-packet gap.
module usb_tx_sched
  import usb_utmi_pkg::*;
#(
  parameter int unsigned IPG_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hs_req,
  input  logic [3:0] hs_pid,
  output logic       hs_done,
  input  logic       dat_req,
  input  logic [3:0] dat_pid,
  input  logic       dat_zlp,
  input  logic [7:0] ep_data,
  input  logic       ep_valid,
  input  logic       ep_last,
  output logic       ep_ready,
  output logic       dat_done,
  output logic       err_underrun,
  output logic [7:0] data_in,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  localparam int unsigned IPG_W     = (IPG_CYCLES == 0) ? 1 : $clog2(IPG_CYCLES + 1);
  localparam tx_state_t   GAP_STATE = (IPG_CYCLES == 0) ? ST_IDLE : ST_IPG;
  localparam logic        GAP_BUSY  = (IPG_CYCLES != 0);

  tx_state_t        state;
  logic             is_hs;
  logic             zlp;
  logic             last;
  logic [15:0]      crc;
  logic [15:0]      crc_next;
  logic [IPG_W-1:0] ipg_cnt;
  logic             pay_need;

  usb_crc16 u_crc16 (
    .crc_in  (crc),
    .data    (ep_data),
    .crc_out (crc_next)
  );

  // A payload byte is needed when the byte now on data_in is followed by payload
  assign pay_need = ((state == ST_PID) && !is_hs && !zlp) || ((state == ST_DATA) && !last);
  assign ep_ready = pay_need && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      is_hs        <= 1'b0;
      zlp          <= 1'b0;
      last         <= 1'b0;
      crc          <= CRC16_INIT;
      ipg_cnt      <= '0;
      data_in      <= 8'h00;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      hs_done      <= 1'b0;
      dat_done     <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      hs_done      <= 1'b0;
      dat_done     <= 1'b0;
      err_underrun <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (hs_req) begin
            is_hs    <= 1'b1;
            zlp      <= 1'b0;
            last     <= 1'b0;
            data_in  <= pid_byte(hs_pid);
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_PID;
          end else if (dat_req) begin
            is_hs    <= 1'b0;
            zlp      <= dat_zlp;
            last     <= 1'b0;
            crc      <= CRC16_INIT;
            data_in  <= pid_byte(dat_pid);
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_PID;
          end
        end
        ST_PID, ST_DATA: begin
          if (tx_ready) begin
            if ((state == ST_PID) && is_hs) begin
              hs_done  <= 1'b1;
              tx_valid <= 1'b0;
              ipg_cnt  <= IPG_W'(IPG_CYCLES);
              busy     <= GAP_BUSY;
              state    <= GAP_STATE;
            end else if (!pay_need) begin
              data_in <= ~crc[7:0];
              state   <= ST_CRC_LO;
            end else if (ep_valid) begin
              data_in <= ep_data;
              crc     <= crc_next;
              last    <= ep_last;
              state   <= ST_DATA;
            end else begin
              // Underrun: abandon the packet without CRC so the host discards it
              tx_valid     <= 1'b0;
              err_underrun <= 1'b1;
              dat_done     <= 1'b1;
              ipg_cnt      <= IPG_W'(IPG_CYCLES);
              busy         <= GAP_BUSY;
              state        <= GAP_STATE;
            end
          end
        end
        ST_CRC_LO: begin
          if (tx_ready) begin
            data_in <= ~crc[15:8];
            state   <= ST_CRC_HI;
          end
        end
        ST_CRC_HI: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            dat_done <= 1'b1;
            ipg_cnt  <= IPG_W'(IPG_CYCLES);
            busy     <= GAP_BUSY;
            state    <= GAP_STATE;
          end
        end
        ST_IPG: begin
          if (ipg_cnt <= IPG_W'(1)) begin
            ipg_cnt <= '0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            ipg_cnt <= ipg_cnt - IPG_W'(1);
          end
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Bench for usb_tx_sched: a packet-level byte scoreboard checked every cycle plus directed scenarios.
module tb_usb_tx_sched;
  import usb_utmi_pkg::*;

  localparam int unsigned IPG = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] b;
    bit         pay_next;
    bit         end_hs;
    bit         end_dat;
    bit         underrun;
    bit         is_pid;
  } exp_t;
  typedef struct {
    logic [7:0] d;
    bit         last;
  } ep_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hs_req, dat_req, dat_zlp;
  logic [3:0] hs_pid, dat_pid;
  logic       hs_done, dat_done, err_underrun;
  logic [7:0] ep_data;
  logic       ep_valid, ep_last, ep_ready;
  logic [7:0] data_in;
  logic       tx_valid, tx_ready, busy;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  ep_t  ep_q[$];
  bq_t  pkt_log;
  bit   mon_en = 1'b0;
  int   tx_mode = 0;
  int   acc_cnt = 0;
  int   acc_goal = 0;

  usb_tx_sched #(.IPG_CYCLES(IPG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hs_req       (hs_req),
    .hs_pid       (hs_pid),
    .hs_done      (hs_done),
    .dat_req      (dat_req),
    .dat_pid      (dat_pid),
    .dat_zlp      (dat_zlp),
    .ep_data      (ep_data),
    .ep_valid     (ep_valid),
    .ep_last      (ep_last),
    .ep_ready     (ep_ready),
    .dat_done     (dat_done),
    .err_underrun (err_underrun),
    .data_in      (data_in),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC as defined on the wire: bits enter LSB-first into an MSB-first register
  function automatic logic [15:0] crc_msb(input bq_t bytes);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int k = 0; k < bytes.size(); k++) begin
      for (int i = 0; i < 8; i++) begin
        fb = r[15] ^ bytes[k][i];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ CRC16_POLY;
      end
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [7:0] b, input bit pn, input bit eh, input bit ed,
                              input bit ur, input bit ip);
    exp_t e;
    e.b = b; e.pay_next = pn; e.end_hs = eh; e.end_dat = ed; e.underrun = ur; e.is_pid = ip;
    return e;
  endfunction

  task automatic push_hs(input logic [3:0] pid);
    exp_q.push_back(mk({~pid, pid}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic push_dat(input logic [3:0] pid, input bq_t pay, input bit zlp, input bit underrun);
    logic [15:0] r;
    logic [7:0]  lo, hi;
    int          n;
    n = pay.size();
    exp_q.push_back(mk({~pid, pid}, !zlp, 1'b0, 1'b0, underrun && (n == 0), 1'b1));
    for (int k = 0; k < n; k++)
      exp_q.push_back(mk(pay[k], underrun || (k != n - 1), 1'b0, 1'b0, underrun && (k == n - 1), 1'b0));
    if (!underrun) begin
      r = crc_msb(pay);
      for (int i = 0; i < 8; i++) begin
        lo[i] = ~r[15-i];
        hi[i] = ~r[7-i];
      end
      exp_q.push_back(mk(lo, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(hi, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    end
  endtask

  task automatic load_ep(input bq_t pay, input bit with_last);
    ep_t x;
    for (int k = 0; k < pay.size(); k++) begin
      x.d = pay[k];
      x.last = with_last && (k == pay.size() - 1);
      ep_q.push_back(x);
    end
  endtask

  task automatic wait_for(input int which, input int limit, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = hs_done;
        1:       hit = dat_done;
        2:       hit = !busy;
        default: hit = (acc_cnt >= acc_goal);
      endcase
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL wait_%s: condition not seen within %0d cycles", name, limit);
    end
    @(posedge clk); #1;
  endtask

  // tx_ready pattern: always ready, or ready one clock in three
  initial begin
    int cyc;
    cyc = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = (tx_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      cyc++;
    end
  end

  // Endpoint byte source
  initial begin
    bit took;
    ep_valid = 1'b0; ep_data = 8'h00; ep_last = 1'b0;
    forever begin
      @(negedge clk);
      took = ep_valid && ep_ready;
      @(posedge clk); #1;
      if (took && ep_q.size() > 0) void'(ep_q.pop_front());
      ep_valid = (ep_q.size() > 0);
      ep_data  = ep_valid ? ep_q[0].d : 8'h00;
      ep_last  = ep_valid ? ep_q[0].last : 1'b0;
    end
  end

  // Scoreboard compare: every cycle while enabled
  initial begin
    bit   p_hs, p_dd, p_ur, p_gap, in_gap, in_pkt;
    int   gap_left;
    exp_t e;
    p_hs = 0; p_dd = 0; p_ur = 0; p_gap = 0; in_gap = 0; in_pkt = 0; gap_left = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        p_hs = 0; p_dd = 0; p_ur = 0; p_gap = 0; in_gap = 0; in_pkt = 0;
        pkt_log.delete();
      end else begin
        chk("hs_done", hs_done, p_hs);
        chk("dat_done", dat_done, p_dd);
        chk("err_underrun", err_underrun, p_ur);
        if (p_gap) begin
          in_gap = 1;
          gap_left = IPG;
        end
        p_hs = 0; p_dd = 0; p_ur = 0; p_gap = 0;
        if (in_gap) begin
          chk("gap_tx_valid", tx_valid, 0);
          chk("gap_busy", busy, gap_left != 0);
          if (gap_left == 0) in_gap = 0;
          else gap_left--;
        end else if (tx_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_tx", tx_valid, 0);
          end else begin
            e = exp_q[0];
            chk("data_in", data_in, e.b);
            chk("ep_ready", ep_ready, e.pay_next && tx_ready);
            chk("busy_tx", busy, 1);
            in_pkt = 1;
            if (tx_ready) begin
              void'(exp_q.pop_front());
              acc_cnt++;
              if (!e.is_pid) pkt_log.push_back(data_in);
              if (e.end_dat) chk("crc_residual", crc_msb(pkt_log), CRC16_RESIDUAL);
              if (e.end_hs) p_hs = 1;
              if (e.end_dat) p_dd = 1;
              if (e.underrun) begin p_dd = 1; p_ur = 1; end
              if (e.end_hs || e.end_dat || e.underrun) begin
                p_gap = 1;
                in_pkt = 0;
                pkt_log.delete();
              end
            end
          end
        end else begin
          chk("ep_ready_idle", ep_ready, 0);
          if (in_pkt) chk("tx_valid_held", tx_valid, 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t   pay;
    string s;
    rst_n = 1'b0;
    hs_req = 1'b0; dat_req = 1'b0; dat_zlp = 1'b0;
    hs_pid = 4'h0; dat_pid = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_data_in", data_in, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_ep_ready", ep_ready, 0);
    chk("rst_pulses", {hs_done, dat_done, err_underrun}, 3'b000);

    // Pin the CRC model against the standard CRC-16 check string
    s = "123456789";
    pay.delete();
    for (int i = 0; i < s.len(); i++) pay.push_back(s[i]);
    chk("model_crc_check", reflect16(crc_msb(pay)), 16'h4B37);

    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // ACK handshake, tx_ready always high
    push_hs(ACK);
    chk("model_ack_byte", exp_q[0].b, 8'hD2);
    hs_pid = ACK; hs_req = 1'b1;
    wait_for(0, 10, "hs_done_ack");
    hs_req = 1'b0;
    wait_for(2, 40, "idle_ack");

    // DATA1 zero-length packet
    pay.delete();
    push_dat(DATA1, pay, 1'b1, 1'b0);
    chk("model_zlp_n", exp_q.size(), 3);
    chk("model_zlp_b0", exp_q[0].b, 8'h4B);
    chk("model_zlp_b1", exp_q[1].b, 8'h00);
    chk("model_zlp_b2", exp_q[2].b, 8'h00);
    dat_pid = DATA1; dat_zlp = 1'b1; dat_req = 1'b1;
    wait_for(1, 20, "dat_done_zlp");
    dat_req = 1'b0; dat_zlp = 1'b0;
    wait_for(2, 40, "idle_zlp");

    // DATA0 with 4 payload bytes, tx_ready one clock in three
    tx_mode = 1;
    pay = '{8'hA5, 8'h01, 8'h80, 8'hFF};
    load_ep(pay, 1'b1);
    push_dat(DATA0, pay, 1'b0, 1'b0);
    chk("model_data0_pid", exp_q[0].b, 8'hC3);
    dat_pid = DATA0; dat_req = 1'b1;
    wait_for(1, 100, "dat_done_data0");
    dat_req = 1'b0;
    wait_for(2, 40, "idle_data0");
    tx_mode = 0;

    // Handshake and data requested together: handshake first
    push_hs(NAK);
    chk("model_nak_byte", exp_q[0].b, 8'h5A);
    pay = '{8'h5A, 8'hC3};
    load_ep(pay, 1'b1);
    push_dat(DATA1, pay, 1'b0, 1'b0);
    hs_pid = NAK; dat_pid = DATA1; hs_req = 1'b1; dat_req = 1'b1;
    wait_for(0, 10, "hs_done_both");
    hs_req = 1'b0;
    wait_for(1, 60, "dat_done_both");
    dat_req = 1'b0;
    wait_for(2, 40, "idle_both");

    // Underrun before the second payload byte
    pay = '{8'h77};
    load_ep(pay, 1'b0);
    push_dat(DATA0, pay, 1'b0, 1'b1);
    dat_pid = DATA0; dat_req = 1'b1;
    wait_for(1, 20, "dat_done_underrun");
    dat_req = 1'b0;
    wait_for(2, 40, "idle_underrun");

    // Asynchronous reset in the middle of a payload
    tx_mode = 1;
    pay = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    load_ep(pay, 1'b1);
    push_dat(DATA1, pay, 1'b0, 1'b0);
    acc_goal = acc_cnt + 2;
    dat_pid = DATA1; dat_req = 1'b1;
    wait_for(3, 40, "mid_data");
    @(negedge clk); #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data_in", data_in, 8'h00);
    chk("arst_ep_ready", ep_ready, 0);
    chk("arst_dat_done", dat_done, 0);
    exp_q.delete();
    ep_q.delete();
    dat_req = 1'b0;
    tx_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    push_hs(STALL);
    chk("model_stall_byte", exp_q[0].b, 8'h1E);
    hs_pid = STALL; hs_req = 1'b1;
    wait_for(0, 4, "hs_done_after_reset");
    hs_req = 1'b0;
    wait_for(2, 40, "idle_final");
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
